// File: rtl/aw_arbiter_2_1.sv
// Two-master AXI4 write-channel arbiter: grants one master the AW slot and keeps
// ownership through the W burst and B response so transactions never interleave.
module aw_arbiter_2_1 #(
  parameter int ARB_MODE       = 1,
  parameter int TIMEOUT_W      = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic S00_AXI_awvalid,
  input  logic S01_AXI_awvalid,
  output logic S00_AXI_awready,
  output logic S01_AXI_awready,
  input  logic M_AXI_awready,
  input  logic M_AXI_wvalid,
  input  logic M_AXI_wready,
  input  logic M_AXI_wlast,
  input  logic M_AXI_bvalid,
  input  logic M_AXI_bready,
  output logic Selected_Slave,
  output logic AW_Grant_Valid,
  output logic W_Enable,
  output logic Write_Busy,
  output logic Timeout_Err
);

  typedef enum logic [1:0] {IDLE, AW_GRANT, W_DATA, B_RESP} state_t;

  localparam logic [TIMEOUT_W-1:0] T_MAX = TIMEOUT_W'(TIMEOUT_CYCLES);
  localparam logic [TIMEOUT_W-1:0] T_PRE = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_t               state, state_nxt;
  logic                 sel, sel_nxt;
  logic                 last_grant, last_grant_nxt;
  logic                 winner;
  logic                 aw_hs, w_last_hs, b_hs, in_wb;
  logic [TIMEOUT_W-1:0] cnt;
  logic                 timeout_err;

  // Fixed mode favours S00; round robin only matters when both request.
  always_comb begin
    winner = 1'b0;
    if (ARB_MODE == 0)
      winner = ~S00_AXI_awvalid;
    else if (S00_AXI_awvalid && S01_AXI_awvalid)
      winner = ~last_grant;
    else
      winner = S01_AXI_awvalid;
  end

  assign aw_hs     = (sel ? S01_AXI_awvalid : S00_AXI_awvalid) & M_AXI_awready;
  assign w_last_hs = M_AXI_wvalid & M_AXI_wready & M_AXI_wlast;
  assign b_hs      = M_AXI_bvalid & M_AXI_bready;
  assign in_wb     = (state == W_DATA) || (state == B_RESP);

  always_comb begin
    state_nxt      = state;
    sel_nxt        = sel;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (S00_AXI_awvalid || S01_AXI_awvalid) begin
          sel_nxt   = winner;
          state_nxt = AW_GRANT;
        end
      end
      AW_GRANT: begin
        if (aw_hs) begin
          last_grant_nxt = sel;
          state_nxt      = W_DATA;
        end
      end
      W_DATA:  if (w_last_hs) state_nxt = B_RESP;
      B_RESP:  if (b_hs)      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state      <= IDLE;
      sel        <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Watchdog only observes; it never forces the FSM out of a stuck burst.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (in_wb && state_nxt != IDLE) begin
        if (cnt != T_MAX) cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
      if (in_wb && cnt == T_PRE) timeout_err <= 1'b1;
    end
  end

  assign Selected_Slave  = sel;
  assign AW_Grant_Valid  = (state == AW_GRANT);
  assign S00_AXI_awready = (state == AW_GRANT) & ~sel & M_AXI_awready;
  assign S01_AXI_awready = (state == AW_GRANT) &  sel & M_AXI_awready;
  assign W_Enable        = (state == W_DATA);
  assign Write_Busy      = (state != IDLE);
  assign Timeout_Err     = timeout_err;

endmodule

// File: tb/tb_aw_arbiter_2_1.sv
// Vector/scoreboard bench: dut 0 is round robin, dut 1 fixed priority, both with
// an 8-cycle watchdog. Outputs packed as {sel, agv, awready0, awready1, wen, busy, to}.
module tb_aw_arbiter_2_1;

  typedef struct packed {
    logic [7:0] in;   // {s00v, s01v, m_awready, wvalid, wready, wlast, bvalid, bready}
    logic [6:0] exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst[2], s00v[2], s01v[2], maw[2], wv[2], wr[2], wl[2], bv[2], br[2];
  logic sel_o[2], agv_o[2], r0_o[2], r1_o[2], wen_o[2], busy_o[2], to_o[2];

  int tests = 0;
  int fails = 0;
  logic [6:0] exp_q[$];

  aw_arbiter_2_1 #(.ARB_MODE(1), .TIMEOUT_W(16), .TIMEOUT_CYCLES(8)) dut_rr (
    .ACLK(clk), .ARESET(rst[0]),
    .S00_AXI_awvalid(s00v[0]), .S01_AXI_awvalid(s01v[0]),
    .S00_AXI_awready(r0_o[0]), .S01_AXI_awready(r1_o[0]),
    .M_AXI_awready(maw[0]), .M_AXI_wvalid(wv[0]), .M_AXI_wready(wr[0]),
    .M_AXI_wlast(wl[0]), .M_AXI_bvalid(bv[0]), .M_AXI_bready(br[0]),
    .Selected_Slave(sel_o[0]), .AW_Grant_Valid(agv_o[0]), .W_Enable(wen_o[0]),
    .Write_Busy(busy_o[0]), .Timeout_Err(to_o[0])
  );

  aw_arbiter_2_1 #(.ARB_MODE(0), .TIMEOUT_W(16), .TIMEOUT_CYCLES(8)) dut_fp (
    .ACLK(clk), .ARESET(rst[1]),
    .S00_AXI_awvalid(s00v[1]), .S01_AXI_awvalid(s01v[1]),
    .S00_AXI_awready(r0_o[1]), .S01_AXI_awready(r1_o[1]),
    .M_AXI_awready(maw[1]), .M_AXI_wvalid(wv[1]), .M_AXI_wready(wr[1]),
    .M_AXI_wlast(wl[1]), .M_AXI_bvalid(bv[1]), .M_AXI_bready(br[1]),
    .Selected_Slave(sel_o[1]), .AW_Grant_Valid(agv_o[1]), .W_Enable(wen_o[1]),
    .Write_Busy(busy_o[1]), .Timeout_Err(to_o[1])
  );

  function automatic logic [6:0] outs(input int d);
    return {sel_o[d], agv_o[d], r0_o[d], r1_o[d], wen_o[d], busy_o[d], to_o[d]};
  endfunction

  function automatic vec_t mk(input logic [7:0] i, input logic [6:0] e);
    vec_t v;
    v.in  = i;
    v.exp = e;
    return v;
  endfunction

  task automatic check(input string nm, input logic [6:0] act, input logic [6:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b ({sel,agv,rdy0,rdy1,wen,busy,to})", nm, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic [7:0] i);
    {s00v[d], s01v[d], maw[d], wv[d], wr[d], wl[d], bv[d], br[d]} = i;
  endtask

  task automatic clear_inputs();
    for (int d = 0; d < 2; d++) drive(d, 8'h00);
  endtask

  // Drive at negedge, queue the expectation, compare just after the rising edge.
  task automatic apply(input int d, input vec_t v, input string nm);
    logic [6:0] e;
    @(negedge clk);
    drive(d, v.in);
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(nm, outs(d), e);
  endtask

  task automatic reset_all();
    @(negedge clk);
    clear_inputs();
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
  endtask

  // Single-beat transaction with both masters requesting throughout.
  task automatic txn(input int d, input logic s, input string nm);
    apply(d, mk(8'b1110_0000, {s, 1'b1, ~s, s, 1'b0, 1'b1, 1'b0}), {nm, "_grant"});
    apply(d, mk(8'b1110_0000, {s, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}), {nm, "_wdata"});
    apply(d, mk(8'b1111_1100, {s, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}), {nm, "_bresp"});
    apply(d, mk(8'b1110_0011, {s, 6'b000000}), {nm, "_idle_gap"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench timeout");
  end

  vec_t t1[8];

  initial begin
    t1[0] = mk(8'b1010_0000, 7'b0110010);
    t1[1] = mk(8'b1010_0000, 7'b0000110);
    t1[2] = mk(8'b0001_1000, 7'b0000110);
    t1[3] = mk(8'b0001_1000, 7'b0000110);
    t1[4] = mk(8'b0001_1000, 7'b0000110);
    t1[5] = mk(8'b0001_1100, 7'b0000010);
    t1[6] = mk(8'b0000_0011, 7'b0000000);
    t1[7] = mk(8'b0000_0000, 7'b0000000);

    clear_inputs();
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rr", outs(0), 7'b0);
    check("reset_fp", outs(1), 7'b0);
    @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Basic 4-beat S00 burst
    for (int i = 0; i < 8; i++) apply(0, t1[i], $sformatf("basic[%0d]", i));

    // Round robin vs fixed priority under continuous contention
    reset_all();
    txn(0, 1'b0, "rr0");
    txn(0, 1'b1, "rr1");
    txn(0, 1'b0, "rr2");
    reset_all();
    txn(1, 1'b0, "fp0");
    txn(1, 1'b0, "fp1");
    txn(1, 1'b0, "fp2");

    // S01 owns AW while downstream stalls; S00 must wait its turn
    reset_all();
    for (int i = 0; i < 5; i++) apply(0, mk(8'b0100_0000, 7'b1100010), $sformatf("stall_s01[%0d]", i));
    for (int i = 0; i < 2; i++) apply(0, mk(8'b1100_0000, 7'b1100010), $sformatf("stall_both[%0d]", i));
    apply(0, mk(8'b1110_0000, 7'b1000110), "stall_accept");
    apply(0, mk(8'b1001_1100, 7'b1000010), "stall_wlast");
    apply(0, mk(8'b1000_0011, 7'b1000000), "stall_bresp");
    apply(0, mk(8'b1000_0000, 7'b0100010), "stall_s00_grant");

    // Watchdog with S01 owning a stalled W burst
    reset_all();
    apply(0, mk(8'b0110_0000, 7'b1101010), "to_grant");
    apply(0, mk(8'b0110_0000, 7'b1000110), "to_wdata");
    for (int k = 1; k <= 10; k++)
      apply(0, mk(8'b0001_0000, (k >= 8) ? 7'b1000111 : 7'b1000110), $sformatf("to_wait[%0d]", k));
    apply(0, mk(8'b0001_1100, 7'b1000011), "to_wlast");
    apply(0, mk(8'b0000_0011, 7'b1000001), "to_bresp");
    apply(0, mk(8'b0000_0000, 7'b1000001), "to_sticky");
    #2;
    rst[0] = 1'b1;
    #1;
    check("to_async_reset", outs(0), 7'b0);
    @(negedge clk);
    clear_inputs();
    rst[0] = 1'b0;

    // Reset in the middle of an S00 burst restores S00 priority
    apply(0, mk(8'b1010_0000, 7'b0110010), "mid_grant");
    apply(0, mk(8'b1010_0000, 7'b0000110), "mid_wdata");
    apply(0, mk(8'b0001_1000, 7'b0000110), "mid_beat1");
    apply(0, mk(8'b0001_1000, 7'b0000110), "mid_beat2");
    #2;
    rst[0] = 1'b1;
    #1;
    check("mid_async_reset", outs(0), 7'b0);
    @(negedge clk);
    clear_inputs();
    rst[0] = 1'b0;
    apply(0, mk(8'b1110_0000, 7'b0110010), "mid_rearb_s00");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
